// File: rtl/system_bus_router.sv
// Routes one system bus master to four slaves by address[29:28] and returns read data in issue order.
// Optional define SYSTEM_BUS_ROUTER_ERROR_EN adds unmapped-address handling and a sticky decode_error output.
module system_bus_router #(
  parameter int PENDING_DEPTH = 4
) (
  input  logic          i_clk,
  input  logic          i_reset,
  output logic          o_master_ready,
  input  logic [31:0]   i_master_addr,
  input  logic [31:0]   i_master_write_data,
  input  logic [3:0]    i_master_byte_enable,
  input  logic          i_master_write_req,
  input  logic          i_master_read_req,
  output logic [31:0]   o_master_read_data,
  output logic          o_master_read_data_valid,
  input  logic [3:0]    i_slave_ready,
  output logic [31:0]   o_slave_addr,
  output logic [31:0]   o_slave_write_data,
  output logic [3:0]    o_slave_byte_enable,
  output logic [3:0]    o_slave_write_req,
  output logic [3:0]    o_slave_read_req,
  input  logic [127:0]  i_slave_read_data,
  input  logic [3:0]    i_slave_read_data_valid
`ifdef SYSTEM_BUS_ROUTER_ERROR_EN
  ,
  output logic          o_decode_error
`endif
);

  localparam int AW = $clog2(PENDING_DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [1:0]    r_q_sel [PENDING_DEPTH];

  logic [1:0]    w_sel;
  logic          w_mapped;
  logic          w_full;
  logic          w_empty;
  logic          w_push;
  logic          w_pop;
  logic [1:0]    w_push_sel;
  logic [1:0]    w_head_sel;
  logic          w_head_err;
  logic [31:0]   w_head_lane;

  assign w_sel   = i_master_addr[29:28];
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign w_empty = (r_wr_ptr == r_rd_ptr);

`ifdef SYSTEM_BUS_ROUTER_ERROR_EN
  logic r_q_err [PENDING_DEPTH];
  logic r_decode_error;

  assign w_mapped   = (i_master_addr[31:30] == 2'b00);
  assign w_head_err = r_q_err[r_rd_ptr[AW-1:0]];
  // Unmapped accesses bypass slave_ready; reads still need a free queue slot.
  assign o_master_ready = (w_mapped ? i_slave_ready[w_sel] : 1'b1) &&
                          !(i_master_read_req && w_full);
  assign o_decode_error = r_decode_error;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_q_err[r_wr_ptr[AW-1:0]] <= !w_mapped;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_decode_error <= 1'b0;
    end else if ((i_master_read_req || i_master_write_req) && !w_mapped && o_master_ready) begin
      r_decode_error <= 1'b1;
    end
  end
`else
  logic w_unused_addr_hi;

  assign w_unused_addr_hi = ^i_master_addr[31:30];
  assign w_mapped         = 1'b1;
  assign w_head_err       = 1'b0;
  assign o_master_ready   = i_slave_ready[w_sel] && !(i_master_read_req && w_full);
`endif

  assign o_slave_addr        = {4'h0, i_master_addr[27:0]};
  assign o_slave_write_data  = i_master_write_data;
  assign o_slave_byte_enable = i_master_byte_enable;

  always_comb begin
    o_slave_write_req = 4'b0000;
    o_slave_read_req  = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      o_slave_write_req[i] = i_master_write_req && w_mapped && (w_sel == 2'(i)) && o_master_ready;
      o_slave_read_req[i]  = i_master_read_req  && w_mapped && (w_sel == 2'(i)) && o_master_ready;
    end
  end

  assign w_push     = i_master_read_req && o_master_ready;
  assign w_push_sel = w_mapped ? w_sel : 2'b00;

  // Only the head slave's valid is honoured; others are dropped.
  assign w_head_sel  = r_q_sel[r_rd_ptr[AW-1:0]];
  assign w_head_lane = i_slave_read_data[{w_head_sel, 5'b00000} +: 32];
  assign w_pop       = !w_empty && (w_head_err || i_slave_read_data_valid[w_head_sel]);

  assign o_master_read_data_valid = w_pop;
  assign o_master_read_data       = !w_pop    ? 32'h0000_0000 :
                                    w_head_err ? 32'hffff_ffff : w_head_lane;

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_q_sel[r_wr_ptr[AW-1:0]] <= w_push_sel;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

endmodule
